// File: rtl/clip_arb.sv
// clip_arb: four-channel round-robin arbiter feeding one shared saturating clip stage, with per-channel clip counters and sticky flags
module clip_arb #(
  parameter int bits_in = 24,
  parameter int bits_out = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*bits_in-1:0] in_data,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  output logic [bits_out-1:0]  out_data,
  output logic [1:0]           out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [1:0]           clip_sel,
  output logic [15:0]          clip_cnt,
  input  logic                 clip_clr,
  output logic [3:0]           clip_flag
);
  logic [1:0] ptr_q, ptr_d, g, idx;
  logic found, load, xfer, clipped;
  logic signed [bits_in-1:0] x;
  logic [bits_in-bits_out:0] top;
  logic [bits_out-1:0] y, out_data_q, out_data_d;
  logic [1:0] out_chan_q, out_chan_d;
  logic out_valid_q, out_valid_d;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [3:0] flag_q, flag_d;
  always_comb begin
    g = ptr_q;
    found = 1'b0;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (in_valid[idx]) begin
        g = idx;
        found = 1'b1;
      end
    end
  end
  assign load = !out_valid_q || out_ready;
  assign xfer = found && load && !rst;
  assign in_ready = xfer ? 4'b0001 << g : 4'b0000;
  assign x = in_data[g*bits_in +: bits_in];
  assign top = x[bits_in-1:bits_out-1];
  assign clipped = !(&top || ~|top);
  assign y = !clipped ? x[bits_out-1:0] :
             x[bits_in-1] ? {1'b1, {(bits_out-1){1'b0}}} : {1'b0, {(bits_out-1){1'b1}}};
  always_comb begin
    ptr_d = xfer ? g + 2'd1 : ptr_q;
    out_data_d = xfer ? y : out_data_q;
    out_chan_d = xfer ? g : out_chan_q;
    out_valid_d = xfer || (out_valid_q && !out_ready);
    flag_d = clip_clr ? 4'b0000 : flag_q | ((xfer && clipped) ? 4'b0001 << g : 4'b0000);
    for (int n = 0; n < 4; n++)
      cnt_d[n] = clip_clr ? 16'd0 :
                 (xfer && clipped && g == 2'(n) && cnt_q[n] != 16'hFFFF) ? cnt_q[n] + 16'd1 : cnt_q[n];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      out_data_q <= '0;
      out_chan_q <= '0;
      out_valid_q <= 1'b0;
      flag_q <= '0;
      for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
    end else begin
      ptr_q <= ptr_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_valid_q <= out_valid_d;
      flag_q <= flag_d;
      for (int n = 0; n < 4; n++) cnt_q[n] <= cnt_d[n];
    end
  end
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign out_valid = out_valid_q;
  assign clip_flag = flag_q;
  assign clip_cnt = cnt_q[clip_sel];
endmodule

// File: tb/tb_clip_arb.sv
// tb_clip_arb: directed and randomized checks of clip_arb against a behavioural reference model
module tb_clip_arb;
  localparam int BI = 24;
  localparam int BO = 16;
  localparam int HI = (1 << (BO - 1)) - 1;
  localparam int LO = -(1 << (BO - 1));
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4*BI-1:0] in_data = '0;
  logic [3:0] in_valid = 4'hF;
  logic [3:0] in_ready;
  logic [BO-1:0] out_data;
  logic [1:0] out_chan;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] clip_sel = '0;
  logic [15:0] clip_cnt;
  logic clip_clr = 1'b0;
  logic [3:0] clip_flag;
  int errors = 0;
  int checks = 0;
  int m_ptr, m_oc;
  logic m_ov;
  logic [15:0] m_od;
  int m_cnt [4];
  logic [3:0] m_flag;
  logic [23:0] vals [4] = '{24'h007FFF, 24'h008000, 24'hFF8000, 24'hFF7FFF};
  logic [15:0] exps [4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
  logic [15:0] hold_d;
  logic [1:0] hold_c;
  always #5 clk = ~clk;
  clip_arb #(.bits_in(BI), .bits_out(BO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .clip_sel(clip_sel), .clip_cnt(clip_cnt), .clip_clr(clip_clr), .clip_flag(clip_flag)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int grant();
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction
  function automatic logic [3:0] exp_ready();
    int gg = grant();
    if (rst || gg < 0 || !(!m_ov || out_ready)) return 4'b0000;
    return 4'b0001 << gg;
  endfunction
  task automatic model_reset();
    m_ptr = 0;
    m_ov = 1'b0;
    m_od = '0;
    m_oc = 0;
    m_flag = '0;
    for (int n = 0; n < 4; n++) m_cnt[n] = 0;
  endtask
  task automatic model_edge();
    int gg = grant();
    logic signed [BI-1:0] s;
    int x, y;
    if (gg >= 0 && (!m_ov || out_ready)) begin
      s = in_data[gg*BI +: BI];
      x = int'(s);
      y = x > HI ? HI : x < LO ? LO : x;
      m_od = 16'(y);
      m_oc = gg;
      m_ov = 1'b1;
      m_ptr = (gg + 1) % 4;
      if (y != x) begin
        if (m_cnt[gg] < 65535) m_cnt[gg]++;
        m_flag[gg] = 1'b1;
      end
    end else if (out_ready) m_ov = 1'b0;
    if (clip_clr) begin
      m_flag = '0;
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
    end
  endtask
  task automatic check_outs();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_chan", 32'(out_chan), 32'(m_oc));
    chk("clip_flag", 32'(clip_flag), 32'(m_flag));
    chk("clip_cnt", 32'(clip_cnt), 32'(m_cnt[clip_sel]));
  endtask
  task automatic tick(input bit en);
    #1;
    if (en) chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    @(posedge clk);
    model_edge();
    #1;
    if (en) check_outs();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    check_outs();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask
  function automatic logic [23:0] rnd_sample();
    case ($urandom_range(0, 3))
      0: return 24'($urandom);
      1: return 24'(HI - 2 + int'($urandom_range(0, 4)));
      2: return 24'(LO - 2 + int'($urandom_range(0, 4)));
      default: return 24'(int'($urandom_range(0, 2000)) - 1000);
    endcase
  endfunction
  task automatic rnd_data();
    for (int n = 0; n < 4; n++) in_data[n*BI +: BI] = rnd_sample();
  endtask
  initial begin
    #1;
    do_reset();
    out_ready = 1'b1;
    clip_sel = 2'd0;
    in_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      in_data = {72'h0, vals[i]};
      tick(1);
      chk("r032_data", 32'(out_data), 32'(exps[i]));
      chk("r032_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 4'b0000;
    tick(1);
    chk("r032_cnt", 32'(clip_cnt), 32'd2);
    chk("r032_flag", 32'(clip_flag), 32'h1);
    in_valid = 4'hF;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rnd_data();
      tick(1);
      chk("r033_chan", 32'(out_chan), 32'(i % 4));
      chk("r033_valid", 32'(out_valid), 32'h1);
    end
    hold_d = out_data;
    hold_c = out_chan;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      tick(1);
      chk("r034_data", 32'(out_data), 32'(hold_d));
      chk("r034_chan", 32'(out_chan), 32'(hold_c));
      chk("r034_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick(1);
    chk("r034_valid", 32'(out_valid), 32'h1);
    chk("r034_next", 32'(out_chan), 32'((hold_c + 1) % 4));
    do_reset();
    clip_sel = 2'd2;
    in_valid = 4'b0100;
    in_data[2*BI +: BI] = 24'h7FFFFF;
    tick(1);
    chk("r035_cnt1", 32'(clip_cnt), 32'd1);
    clip_clr = 1'b1;
    tick(1);
    clip_clr = 1'b0;
    chk("r035_clr_cnt", 32'(clip_cnt), 32'd0);
    chk("r035_clr_flag", 32'(clip_flag[2]), 32'h0);
    clip_sel = 2'd1;
    in_valid = 4'b0010;
    in_data[BI +: BI] = 24'h800000;
    for (int i = 0; i < 65540; i++) tick(0);
    in_valid = 4'b0000;
    tick(1);
    chk("r035_sat", 32'(clip_cnt), 32'hFFFF);
    do_reset();
    in_valid = 4'b0010;
    tick(1);
    out_ready = 1'b0;
    in_valid = 4'b0000;
    tick(1);
    chk("r036_pre_valid", 32'(out_valid), 32'h1);
    in_valid = 4'b1010;
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("r036_async", 32'(out_valid), 32'h0);
    do_reset();
    tick(1);
    chk("r036_first", 32'(out_chan), 32'd1);
    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom);
      rnd_data();
      out_ready = $urandom_range(0, 3) != 0;
      clip_clr = $urandom_range(0, 15) == 0;
      clip_sel = 2'($urandom);
      tick(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
